// File: rtl/par_to_ser_pkg.sv
// Shared types and frame-length helper for the parallel-to-serial stage.
// Build option PISO_PARITY_EN appends an even-parity bit to every frame.
package par_to_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

`ifdef PISO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int frame_len(int w, bit par);
    return w + int'(par);
  endfunction

endpackage

// File: rtl/par_to_ser_if.sv
// Word-side handshake and serial-side outputs of par_to_ser.
// slave is the serializer's view; master is the source/monitor view.
interface par_to_ser_if #(
  parameter int DATA_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  ser_dout;
  logic                  ser_valid;
  logic                  ser_sof;
  logic                  busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_dout, ser_valid, ser_sof, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_dout, ser_valid, ser_sof, busy
  );
endinterface

// File: rtl/par_to_ser_hold.sv
// One-entry holding register that parks a word accepted mid-frame
// until the shifter finishes the current frame.
module par_to_ser_hold
  import par_to_ser_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_tb,
  input  logic                  load_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  full_q, full_d;

  always_ff @(posedge clk or negedge rst_tb) begin
    if (!rst_tb) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  // load and pop are mutually exclusive: loads only happen while empty
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/par_to_ser.sv
// Parallel-in serial-out stage, MSB first, gapless back-to-back frames.
// Build option PISO_PARITY_EN adds an even-parity bit after the LSB.
//
// state | meaning
// IDLE  | no frame in flight, serial outputs low
// SHIFT | driving frame bit bit_cnt on ser_dout
module par_to_ser
  import par_to_ser_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_tb,
  par_to_ser_if.slave  bus
);

  localparam int FRAME = frame_len(DATA_WIDTH, PARITY_EN);
  localparam int CNT_W = $clog2(FRAME);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);

  piso_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  sof_q, sof_d;
`ifdef PISO_PARITY_EN
  logic                  par_q, par_d;
`endif

  logic                  hold_load, hold_pop, hold_full;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  accept;

  par_to_ser_hold #(.DATA_WIDTH(DATA_WIDTH)) u_hold (
    .clk    (clk),
    .rst_tb (rst_tb),
    .load_i (hold_load),
    .pop_i  (hold_pop),
    .data_i (bus.in_data),
    .data_o (hold_data),
    .full_o (hold_full)
  );

  assign accept = bus.in_valid && !hold_full;

  always_ff @(posedge clk or negedge rst_tb) begin
    if (!rst_tb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    hold_load = 1'b0;
    hold_pop  = 1'b0;
`ifdef PISO_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shift_d = bus.in_data;
`ifdef PISO_PARITY_EN
          par_d   = ^bus.in_data;
`endif
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          // a parked word wins over a fresh offer; in_ready is low then anyway
          if (hold_full) begin
            hold_pop = 1'b1;
            cnt_d    = '0;
            shift_d  = hold_data;
`ifdef PISO_PARITY_EN
            par_d    = ^hold_data;
`endif
          end else if (accept) begin
            cnt_d   = '0;
            shift_d = bus.in_data;
`ifdef PISO_PARITY_EN
            par_d   = ^bus.in_data;
`endif
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            shift_d = '0;
          end
        end else begin
          cnt_d     = cnt_q + 1'b1;
          shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
          hold_load = accept;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs are registered from next-state values so they are glitch-free
  always_comb begin
    valid_d = (state_d == SHIFT);
    sof_d   = valid_d && (cnt_d == '0);
    dout_d  = valid_d && shift_d[DATA_WIDTH-1];
`ifdef PISO_PARITY_EN
    if (cnt_d == CNT_LAST) begin
      dout_d = valid_d && par_d;
    end
`endif
  end

  assign bus.ser_dout  = dout_q;
  assign bus.ser_valid = valid_q;
  assign bus.ser_sof   = sof_q;
  assign bus.in_ready  = !hold_full;
  assign bus.busy      = (state_q == SHIFT) || hold_full;

endmodule

// File: tb/tb_par_to_ser.sv
// Directed self-checking bench for par_to_ser (DATA_WIDTH=4), with and
// without PISO_PARITY_EN.
module tb_par_to_ser;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FR = W + 1;
`else
  localparam int FR = W;
`endif

  logic clk = 1'b0;
  logic rst_tb = 1'b0;
  always #5 clk = ~clk;

  par_to_ser_if #(.DATA_WIDTH(W)) bus ();

  par_to_ser #(.DATA_WIDTH(W)) dut (
    .clk    (clk),
    .rst_tb (rst_tb),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [W-1:0] tx_q[$];
  logic         exp_bits[$];
  int           rdy_low;
  logic [W-1:0] sipo = '0;

  // reference deserializer: shifts into its LSB on every valid bit
  always @(posedge clk) begin
    if (bus.ser_valid) sipo <= {sipo[W-2:0], bus.ser_dout};
  end

  function automatic void push_frame(logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) exp_bits.push_back(w[i]);
`ifdef PISO_PARITY_EN
    exp_bits.push_back(^w);
`endif
  endfunction

  task automatic drive_words();
    int   idx = 0;
    int   budget = 0;
    logic rdy;
    @(posedge clk); #1;
    while (idx < tx_q.size()) begin
      bus.in_valid = 1'b1;
      bus.in_data  = tx_q[idx];
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk); #1;
      if (rdy) idx++;
      budget++;
      if (budget > 200) begin
        checks++; failures++;
        $display("FAIL drive_timeout: accepted %0d of %0d words", idx, tx_q.size());
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom);
  endtask

  task automatic check_stream(input string name);
    int   n = exp_bits.size();
    logic seen = 1'b0;
    rdy_low = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.ser_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (seen !== 1'b1) begin
      failures++;
      $display("FAIL %s_start: ser_valid never rose", name);
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (!bus.in_ready) rdy_low++;
      checks++;
      if (bus.ser_valid !== 1'b1) begin
        failures++;
        $display("FAIL %s_valid bit %0d: got %b want 1", name, i, bus.ser_valid);
      end
      checks++;
      if (bus.ser_dout !== exp_bits[i]) begin
        failures++;
        $display("FAIL %s_dout bit %0d: got %b want %b", name, i, bus.ser_dout, exp_bits[i]);
      end
      checks++;
      if (bus.ser_sof !== ((i % FR) == 0)) begin
        failures++;
        $display("FAIL %s_sof bit %0d: got %b want %b", name, i, bus.ser_sof, (i % FR) == 0);
      end
      checks++;
      if (bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL %s_busy bit %0d: got %b want 1", name, i, bus.busy);
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.ser_valid, bus.ser_dout, bus.ser_sof} !== 3'b000) begin
      failures++;
      $display("FAIL %s_end: valid/dout/sof got %b want 000", name,
               {bus.ser_valid, bus.ser_dout, bus.ser_sof});
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hF;
    #3;
    checks++;
    if ({bus.ser_valid, bus.ser_dout, bus.ser_sof, bus.busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: valid/dout/sof/busy got %b want 0000",
               {bus.ser_valid, bus.ser_dout, bus.ser_sof, bus.busy});
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    #1;
    bus.in_valid = 1'b0;
    rst_tb = 1'b1;
    // hold reset across live edges with a word on offer: nothing may be taken
    @(posedge clk); #1;
    rst_tb = 1'b0;
    bus.in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.ser_valid, bus.in_ready} !== 3'b001) begin
        failures++;
        $display("FAIL reset_no_accept: busy/valid/ready got %b want 001",
                 {bus.busy, bus.ser_valid, bus.in_ready});
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst_tb = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.ser_valid} !== 2'b00) begin
      failures++;
      $display("FAIL reset_release_idle: busy/valid got %b want 00", {bus.busy, bus.ser_valid});
    end
  endtask

  task automatic test_single();
    tx_q = '{4'b1101};
    exp_bits.delete();
    push_frame(4'b1101);  // 1,1,0,1 (+parity 1)
    fork
      drive_words();
      check_stream("single");
    join
  endtask

  task automatic test_back_to_back();
    tx_q = '{4'b0110, 4'b0101, 4'b1100};
    exp_bits.delete();
    foreach (tx_q[i]) push_frame(tx_q[i]);
    fork
      drive_words();
      check_stream("b2b");
    join
    // hold busy from the second accept until each frame's last bit, twice
    checks++;
    if (rdy_low !== 2 * (FR - 1)) begin
      failures++;
      $display("FAIL b2b_in_ready_low: got %0d cycles want %0d", rdy_low, 2 * (FR - 1));
    end
  endtask

  task automatic test_reset_mid();
    tx_q = '{4'b0111};
    fork
      drive_words();
      begin
        for (int c = 0; c < 12; c++) begin
          @(negedge clk);
          if (bus.ser_valid) break;
        end
        checks++;
        if ({bus.ser_valid, bus.ser_dout, bus.ser_sof} !== 3'b101) begin
          failures++;
          $display("FAIL midrst_bit0: valid/dout/sof got %b want 101",
                   {bus.ser_valid, bus.ser_dout, bus.ser_sof});
        end
        @(negedge clk);
        checks++;
        if (bus.ser_dout !== 1'b1) begin
          failures++;
          $display("FAIL midrst_bit1: got %b want 1", bus.ser_dout);
        end
      end
    join
    #2;
    rst_tb = 1'b0;
    #1;
    checks++;
    if ({bus.ser_valid, bus.ser_dout, bus.busy, bus.in_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_async: valid/dout/busy/ready got %b want 0001",
               {bus.ser_valid, bus.ser_dout, bus.busy, bus.in_ready});
    end
    @(posedge clk); #1;
    rst_tb = 1'b1;
    tx_q = '{4'b1000};
    exp_bits.delete();
    push_frame(4'b1000);
    fork
      drive_words();
      check_stream("after_rst");
    join
  endtask

`ifndef PISO_PARITY_EN
  task automatic test_chain();
    int   k = 0;
    int   nbits = 0;
    logic pending = 1'b0;
    tx_q = '{4'b1101, 4'b0110, 4'b0101, 4'b1100, 4'b0111};
    fork
      drive_words();
      begin
        for (int c = 0; c < 60 && k < 5; c++) begin
          @(negedge clk);
          if (pending) begin
            checks++;
            if (sipo !== tx_q[k]) begin
              failures++;
              $display("FAIL chain_word %0d: sipo got %b want %b", k, sipo, tx_q[k]);
            end
            k++;
            pending = 1'b0;
          end
          if (bus.ser_valid) begin
            nbits++;
            if (nbits % W == 0) pending = 1'b1;
          end
        end
        if (k < 5) begin
          checks++; failures++;
          $display("FAIL chain_timeout: got %0d words want 5", k);
        end
      end
    join
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
`ifndef PISO_PARITY_EN
    test_chain();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
